// File: rtl/ex_issue_arbiter.sv
// Two-station issue arbiter for the shared execution unit: instruction-level
// round-robin ownership, memory stall, NOP squash and per-station issue counters.

module ex_issue_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst)                      r_cnt <= '0;
    else if (i_clr)                 r_cnt <= '0;
    else if (i_inc && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module ex_issue_arbiter #(
  parameter logic [19:0] NOP        = 20'h00F00,
  parameter bit          SQUASH_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        rs0_valid,
  input  logic [19:0] rs0_uop,
  input  logic [15:0] rs0_data,
  input  logic        rs0_last,
  output logic        rs0_sched_ack,
  input  logic        rs1_valid,
  input  logic [19:0] rs1_uop,
  input  logic [15:0] rs1_data,
  input  logic        rs1_last,
  output logic        rs1_sched_ack,
  input  logic        ex_ready,
  input  logic        mem_busy,
  output logic        ex_issue,
  output logic [19:0] ex_uop,
  output logic [15:0] ex_data,
  output logic        ex_src,
  input  logic        cnt_clr,
  output logic [15:0] issue_cnt0,
  output logic [15:0] issue_cnt1
);
  localparam int NUM_RS = 2;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t r_state, w_state_nxt;
  logic   r_rr, w_rr_nxt;

  logic [NUM_RS-1:0]             w_valid, w_last, w_ack, w_inc;
  logic [NUM_RS-1:0][19:0]       w_uop;
  logic [NUM_RS-1:0][15:0]       w_data, w_cnt;

  logic        w_sel, w_sel_vld, w_is_nop, w_consume, w_issue;
  logic [19:0] w_sel_uop;

  logic        r_issue, r_src;
  logic [19:0] r_uop;
  logic [15:0] r_data;

  assign w_valid = {rs1_valid, rs0_valid};
  assign w_last  = {rs1_last,  rs0_last};
  assign w_uop   = {rs1_uop,   rs0_uop};
  assign w_data  = {rs1_data,  rs0_data};

  // Station selection: owner only while an instruction is in flight,
  // otherwise the rr pointer breaks ties between two valid stations.
  always_comb begin
    w_sel     = 1'b0;
    w_sel_vld = 1'b0;
    case (r_state)
      OWN0: begin
        w_sel     = 1'b0;
        w_sel_vld = w_valid[0];
      end
      OWN1: begin
        w_sel     = 1'b1;
        w_sel_vld = w_valid[1];
      end
      default: begin
        w_sel_vld = |w_valid;
        if (&w_valid)        w_sel = r_rr;
        else if (w_valid[1]) w_sel = 1'b1;
        else                 w_sel = 1'b0;
      end
    endcase
  end

  assign w_sel_uop = w_uop[w_sel];
  assign w_is_nop  = SQUASH_NOP && (w_sel_uop == NOP);
  assign w_consume = w_sel_vld && !mem_busy && (ex_ready || w_is_nop);
  assign w_issue   = w_consume && !w_is_nop;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    if (w_consume) begin
      if (w_last[w_sel]) begin
        w_state_nxt = IDLE;
        w_rr_nxt    = ~w_sel;
      end else begin
        w_state_nxt = w_sel ? OWN1 : OWN0;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // ex_uop/ex_data/ex_src keep the last issued uop across bubbles.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_issue <= 1'b0;
      r_uop   <= NOP;
      r_data  <= '0;
      r_src   <= 1'b0;
    end else begin
      r_issue <= w_issue;
      if (w_issue) begin
        r_uop  <= w_sel_uop;
        r_data <= w_data[w_sel];
        r_src  <= w_sel;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_RS; g++) begin : g_rs
      assign w_ack[g] = w_consume && (w_sel == g[0]) && !a_rst;
      assign w_inc[g] = w_issue && (w_sel == g[0]);
      ex_issue_cnt #(.W(16)) u_cnt (
        .clk   (clk),
        .a_rst (a_rst),
        .i_clr (cnt_clr),
        .i_inc (w_inc[g]),
        .o_cnt (w_cnt[g])
      );
    end
  endgenerate

  assign rs0_sched_ack = w_ack[0];
  assign rs1_sched_ack = w_ack[1];
  assign ex_issue      = r_issue;
  assign ex_uop        = r_uop;
  assign ex_data       = r_data;
  assign ex_src        = r_src;
  assign issue_cnt0    = w_cnt[0];
  assign issue_cnt1    = w_cnt[1];
endmodule

// File: tb/tb_ex_issue_arbiter.sv
// Directed bench for ex_issue_arbiter: vector table for arbitration/stall/squash
// plus sequences for async reset and counter saturation/clear.

module tb_ex_issue_arbiter;
  logic        clk, a_rst;
  logic        rs0_valid, rs0_last, rs0_sched_ack;
  logic [19:0] rs0_uop;
  logic [15:0] rs0_data;
  logic        rs1_valid, rs1_last, rs1_sched_ack;
  logic [19:0] rs1_uop;
  logic [15:0] rs1_data;
  logic        ex_ready, mem_busy, ex_issue, ex_src, cnt_clr;
  logic [19:0] ex_uop;
  logic [15:0] ex_data, issue_cnt0, issue_cnt1;

  int checks = 0;
  int failures = 0;

  ex_issue_arbiter dut (
    .clk(clk), .a_rst(a_rst),
    .rs0_valid(rs0_valid), .rs0_uop(rs0_uop), .rs0_data(rs0_data),
    .rs0_last(rs0_last), .rs0_sched_ack(rs0_sched_ack),
    .rs1_valid(rs1_valid), .rs1_uop(rs1_uop), .rs1_data(rs1_data),
    .rs1_last(rs1_last), .rs1_sched_ack(rs1_sched_ack),
    .ex_ready(ex_ready), .mem_busy(mem_busy),
    .ex_issue(ex_issue), .ex_uop(ex_uop), .ex_data(ex_data), .ex_src(ex_src),
    .cnt_clr(cnt_clr), .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic v0; logic [19:0] u0; logic l0;
    logic v1; logic [19:0] u1; logic l1;
    logic rdy, mb, clr;
    logic a0, a1, iss;
    logic [19:0] uop; logic src;
    logic [15:0] c0, c1;
  } vec_t;

  // Operand is derived from the uop so the expected ex_data follows ex_uop/ex_src.
  function automatic logic [15:0] dat(input logic s, input logic [19:0] u);
    return s ? {4'hB, u[11:0]} : {4'hA, u[11:0]};
  endfunction

  function automatic vec_t mk(
    input logic v0, input logic [19:0] u0, input logic l0,
    input logic v1, input logic [19:0] u1, input logic l1,
    input logic rdy, input logic mb, input logic clr,
    input logic a0, input logic a1, input logic iss,
    input logic [19:0] uop, input logic src,
    input logic [15:0] c0, input logic [15:0] c1);
    vec_t t;
    t.v0 = v0; t.u0 = u0; t.l0 = l0; t.v1 = v1; t.u1 = u1; t.l1 = l1;
    t.rdy = rdy; t.mb = mb; t.clr = clr; t.a0 = a0; t.a1 = a1; t.iss = iss;
    t.uop = uop; t.src = src; t.c0 = c0; t.c1 = c1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [19:0] u0, input logic l0,
                       input logic v1, input logic [19:0] u1, input logic l1,
                       input logic rdy, input logic mb, input logic clr);
    rs0_valid = v0; rs0_uop = u0; rs0_data = dat(1'b0, u0); rs0_last = l0;
    rs1_valid = v1; rs1_uop = u1; rs1_data = dat(1'b1, u1); rs1_last = l1;
    ex_ready = rdy; mem_busy = mb; cnt_clr = clr;
  endtask

  vec_t vt[$];

  initial begin
    // v0 u0 l0 v1 u1 l1 rdy mb clr | a0 a1 iss uop src c0 c1
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 0, 0, 1, 0, 1, 20'h1,  0, 1, 0)); // alternation
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 0, 0, 0, 1, 1, 20'h2,  1, 1, 1));
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 0, 0, 1, 0, 1, 20'h1,  0, 2, 1));
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 0, 0, 0, 1, 1, 20'h2,  1, 2, 2));
    vt.push_back(mk(1, 20'h3,  1, 0, 20'h2,  1, 1, 0, 0, 1, 0, 1, 20'h3,  0, 3, 2)); // rr -> 1
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h11, 0, 1, 0, 0, 0, 1, 1, 20'h11, 1, 3, 3)); // OWN1
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h12, 0, 1, 0, 0, 0, 1, 1, 20'h12, 1, 3, 4));
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h13, 1, 1, 0, 0, 0, 1, 1, 20'h13, 1, 3, 5));
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 0, 0, 1, 0, 1, 20'h1,  0, 4, 5)); // RS0 next
    vt.push_back(mk(1, 20'h21, 0, 0, 20'h2,  1, 1, 0, 0, 1, 0, 1, 20'h21, 0, 5, 5)); // OWN0
    vt.push_back(mk(1, 20'h22, 0, 1, 20'h2,  1, 1, 1, 0, 0, 0, 0, 20'h21, 0, 5, 5)); // stall x4
    vt.push_back(mk(1, 20'h22, 0, 1, 20'h2,  1, 1, 1, 0, 0, 0, 0, 20'h21, 0, 5, 5));
    vt.push_back(mk(1, 20'h22, 0, 1, 20'h2,  1, 1, 1, 0, 0, 0, 0, 20'h21, 0, 5, 5));
    vt.push_back(mk(1, 20'h22, 0, 1, 20'h2,  1, 1, 1, 0, 0, 0, 0, 20'h21, 0, 5, 5));
    vt.push_back(mk(1, 20'h22, 1, 1, 20'h2,  1, 1, 0, 0, 1, 0, 1, 20'h22, 0, 6, 5)); // resume OWN0
    vt.push_back(mk(0, 20'h1,  1, 1, 20'h31, 1, 0, 0, 0, 0, 0, 0, 20'h22, 0, 6, 5)); // ex_ready=0
    vt.push_back(mk(0, 20'h1,  1, 1, 20'h31, 1, 1, 0, 0, 0, 1, 1, 20'h31, 1, 6, 6));
    vt.push_back(mk(1, 20'hF00,1, 0, 20'h2,  1, 0, 0, 0, 1, 0, 0, 20'h31, 1, 6, 6)); // NOP squash
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 0, 0, 0, 1, 1, 20'h2,  1, 6, 7)); // rr was 1
    vt.push_back(mk(1, 20'h1,  1, 1, 20'h2,  1, 1, 1, 0, 0, 0, 0, 20'h2,  1, 6, 7)); // busy in IDLE
    vt.push_back(mk(0, 20'h1,  1, 0, 20'h2,  1, 1, 0, 0, 0, 0, 0, 20'h2,  1, 6, 7)); // none valid

    a_rst = 1'b1;
    drive(1, 20'h1, 1, 1, 20'h2, 1, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", rs0_sched_ack, 0);
    chk("rst_ack1", rs1_sched_ack, 0);
    chk("rst_issue", ex_issue, 0);
    chk("rst_uop", ex_uop, 20'h00F00);
    chk("rst_data", ex_data, 0);
    chk("rst_src", ex_src, 0);
    chk("rst_cnt0", issue_cnt0, 0);
    chk("rst_cnt1", issue_cnt1, 0);
    a_rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].v0, vt[i].u0, vt[i].l0, vt[i].v1, vt[i].u1, vt[i].l1,
            vt[i].rdy, vt[i].mb, vt[i].clr);
      #1;
      chk($sformatf("v%0d_ack0", i), rs0_sched_ack, vt[i].a0);
      chk($sformatf("v%0d_ack1", i), rs1_sched_ack, vt[i].a1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_issue", i), ex_issue, vt[i].iss);
      chk($sformatf("v%0d_uop", i), ex_uop, vt[i].uop);
      chk($sformatf("v%0d_data", i), ex_data, dat(vt[i].src, vt[i].uop));
      chk($sformatf("v%0d_src", i), ex_src, vt[i].src);
      chk($sformatf("v%0d_cnt0", i), issue_cnt0, vt[i].c0);
      chk($sformatf("v%0d_cnt1", i), issue_cnt1, vt[i].c1);
    end

    // Enter OWN1, then reset asynchronously between edges.
    drive(0, 20'h1, 1, 1, 20'h41, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("own1_issue", ex_issue, 1);
    chk("own1_src", ex_src, 1);
    drive(1, 20'h1, 1, 1, 20'h42, 0, 1, 0, 0);
    #2;
    a_rst = 1'b1;
    #1;
    chk("arst_issue", ex_issue, 0);
    chk("arst_uop", ex_uop, 20'h00F00);
    chk("arst_ack1", rs1_sched_ack, 0);
    chk("arst_cnt1", issue_cnt1, 0);
    #1;
    a_rst = 1'b0;
    #1;
    chk("post_rst_ack0", rs0_sched_ack, 1);
    chk("post_rst_ack1", rs1_sched_ack, 0);
    @(posedge clk);
    #1;
    chk("post_rst_src", ex_src, 0);
    chk("post_rst_uop", ex_uop, 20'h1);
    chk("post_rst_cnt0", issue_cnt0, 1);

    // Clear alone, then walk issue_cnt0 up to saturation.
    drive(0, 20'h1, 1, 0, 20'h2, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    chk("clr_cnt0", issue_cnt0, 0);
    drive(1, 20'h5, 1, 0, 20'h2, 1, 1, 0, 0);
    for (int k = 0; k < 65534; k++) @(posedge clk);
    #1;
    chk("pre_sat_cnt0", issue_cnt0, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt0", k), issue_cnt0, 16'hFFFF);
    end
    chk("sat_cnt1", issue_cnt1, 0);
    cnt_clr = 1'b1;
    #1;
    chk("clr_issue_ack0", rs0_sched_ack, 1);
    @(posedge clk);
    #1;
    chk("clr_issue_cnt0", issue_cnt0, 0);
    chk("clr_issue_issue", ex_issue, 1);
    cnt_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_issue_arbiter.md
# ex_issue_arbiter

Shares the single execution unit between two reservation stations (RS0, RS1). Each cycle, one station's next uop and operand are selected and registered toward the execution stage. The station's scheduling acknowledge is returned in the same cycle. A station owns the unit for the whole multi-uop instruction; ownership alternates round-robin between instructions. The block also stalls on memory, squashes NOPs and keeps per-station issue counters.

## Interface
Parameters:
- NOP, 20'h00F00, uop encoding treated as a bubble.
- SQUASH_NOP, 1, when 1 a NOP is consumed from a station without being issued.

Ports (decided: one clock `clk`; reset `a_rst` is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- a_rst  in  1  asynchronous active-high reset
- rs0_valid  in  1  RS0 holds a valid instruction
- rs0_uop  in  20  RS0 next uop
- rs0_data  in  16  RS0 operand
- rs0_last  in  1  rs0_uop is the final uop of its instruction
- rs0_sched_ack  out  1  RS0 uop consumed this cycle
- rs1_valid / rs1_uop / rs1_data / rs1_last / rs1_sched_ack: same meanings for RS1
- ex_ready  in  1  execution unit can accept a uop
- mem_busy  in  1  memory stall, blocks all consumption
- ex_issue  out  1  registered: ex_uop/ex_data valid
- ex_uop  out  20  registered issued uop
- ex_data  out  16  registered issued operand
- ex_src  out  1  registered: station that supplied ex_uop
- cnt_clr  in  1  synchronous clear of both counters
- issue_cnt0, issue_cnt1  out  16  saturating issued-uop counts

## Operation
State is held in an FSM with states IDLE, OWN0 and OWN1, plus a round-robin pointer `rr`.

Selection:
- IDLE, both stations valid: select the station indicated by `rr`.
- IDLE, one station valid: select that station.
- IDLE, none valid: no selection.
- OWNn: select only station n. No selection while rsn_valid=0; state is held.

Consume condition: selected, valid and ~mem_busy, and either ex_ready=1 or the uop is squashed (SQUASH_NOP=1 and uop==NOP).
- rsn_sched_ack = consume for the selected station; it is combinational.
- The other station's ack is always 0.

Issue on a consume of a non-squashed uop:
- Next edge: ex_issue=1; ex_uop, ex_data and ex_src are loaded.
- issue_cntn increments, saturating at 16'hFFFF.

Squashed NOP:
- Acked.
- ex_issue=0 next cycle.
- Counter unchanged.
- Still counts toward last/ownership.

No consume: ex_issue=0 next cycle. ex_uop and ex_data hold their previous values.

Transitions on consume:
- rsn_last=0: go to (or stay in) OWNn.
- rsn_last=1: go to IDLE and set rr = ~n.

cnt_clr:
- Zeroes both counters.
- Has priority over an increment in the same cycle.

## Timing
- Reset values:
  - state=IDLE, rr=0
  - ex_issue=0, ex_uop=NOP, ex_data=0, ex_src=0
  - counters=0
  - acks=0 while a_rst is high.
- Latency: ack and issue register load happen on the same edge. Station uop to ex_uop is 1 cycle.
- Throughput: one uop per cycle with no bubble between instructions. A last uop from RS0 can be followed next cycle by RS1 if RS1 is valid.
- mem_busy=1 forces both acks to 0 regardless of state. ex_issue=0 on the following cycle.
- ex_ready=0 blocks non-squashed consumes. State and rr hold.
- Reset mid-instruction returns to IDLE/rr=0 immediately. Ownership is not retained.
- Single-uop instructions (last=1 on the first uop) never enter OWNn.

## Test plan
- Alternation:
  - Stimulus: both stations valid continuously, every uop last=1, uops 20'h00001/20'h00002, ex_ready=1.
  - Required: acks alternate RS0, RS1, RS0 …; ex_src toggles each cycle; counters each advance by 1 per 2 cycles.
- Ownership:
  - Stimulus: RS1 issues a 3-uop instruction (last on the third) while RS0 is valid throughout, rr=1.
  - Required: three consecutive RS1 acks, then an RS0 ack; rs0_sched_ack stays 0 during OWN1.
- Stall:
  - Stimulus: mem_busy=1 for 4 cycles mid-instruction in OWN0.
  - Required: no acks, ex_issue=0 for those cycles, state stays OWN0; issue resumes on the cycle after mem_busy falls.
- NOP squash:
  - Stimulus: RS0 uop=20'h00F00 last=1 with ex_ready=0.
  - Required: rs0_sched_ack=1, ex_issue=0, issue_cnt0 unchanged, rr becomes 1.
- Counter saturation and clear:
  - Stimulus: preload issue_cnt0 to 16'hFFFE, issue 3 uops, then assert cnt_clr coincident with an issue.
  - Required: counter reads FFFF, FFFF, then 0.
- Reset mid-operation:
  - Stimulus: assert a_rst asynchronously during OWN1.
  - Required: ex_issue=0, ex_uop=20'h00F00 immediately. After release with both stations valid, the first ack goes to RS0.
